relu_maxpool2x2: RTL and testbench
==================================

Name: relu_maxpool2x2

Overview:
Sequential post-convolution stage that consumes the flattened filtered matrix produced by the 3x3 convolution stage. It applies optional ReLU and 2x2 stride-2 max pooling. The block is a start/done engine: it latches the input frame, evaluates one pooling window per clock, and presents a flattened pooled matrix. This matrix feeds the next layer or the testbench.

Parameters:
total_bits, 16, width of one signed fixed-point element
frac_bits, 8, fractional bits; informational only, since max and ReLU are format-agnostic
max_rows, 6, maximum filtered-matrix rows; this is the conv stage's max_rows-2
max_cols, 6, maximum filtered-matrix columns; this is the conv stage's max_cols-2

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request to process the frame on in_matrix; sampled only in IDLE
relu_en  input  1  when 1, clamp negative results to 0; latched at start
in_rows  input  4  valid rows of the filtered matrix (conv rows-2)
in_cols  input  4  valid columns of the filtered matrix (conv cols-2)
in_matrix  input  max_rows*max_cols*total_bits  flattened signed input; element (r,c) at bit offset (r*max_cols+c)*total_bits
busy  output  1  high while windows are being evaluated
done  output  1  one-cycle pulse when pooled_matrix is final
pooled_matrix  output  (max_rows/2)*(max_cols/2)*total_bits  flattened result; element (pr,pc) at offset (pr*(max_cols/2)+pc)*total_bits

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, pooled_matrix=0, internal counters=0.
- Reset mid-operation: aborts the frame. There is no done pulse, and the outputs are cleared on that edge.
- States:
  - IDLE: waits for start.
  - POOL: evaluates one window per cycle.
  - DONE: holds for one cycle with done=1, then returns to IDLE.
- IDLE with start=1, on the same edge:
  - latch in_matrix, relu_en and the effective dims;
  - clear pooled_matrix;
  - set counters pr=pc=0;
  - go to POOL, or go directly to DONE if PR==0 or PC==0.
- Effective dims:
  - R = min(in_rows, max_rows); C = min(in_cols, max_cols).
  - PR = R/2 and PC = C/2, truncating; an odd last row or column is dropped.
- Busy: busy=1 exactly while in POOL.
- POOL, each cycle:
  - m = signed max of elements (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1) from the latched copy.
  - If relu_en and m<0, then m=0.
  - Write m to slot (pr,pc).
  - Advance pc. On pc==PC-1, wrap pc to 0 and increment pr.
  - After slot (PR-1,PC-1), go to DONE.
- Latency: start sampled at edge 0; busy is high for PR*PC cycles; done is high in the cycle after the last write. For a full 6x6 input that is 9 busy cycles, and done is asserted in cycle 10.
- Comparisons are full-width signed two's complement. Ties select either value, since the value is identical. No saturation is needed because the output width equals the input width.
- Unused slots (pr>=PR or pc>=PC) read 0.
- pooled_matrix holds its value after done until the next accepted start or reset.
- Input changes: in_matrix may change after the start edge without affecting the result.
- start while in POOL or DONE is ignored; it is not queued.
- Simultaneous rst and start: rst wins.
- A start in the same cycle as done (state DONE) is ignored; start is accepted in the following IDLE cycle.

Test Plan:
1. 6x6 input, element(r,c)=r*6+c (as Q8.8 integers), relu_en=0 -> after 9 busy cycles, done pulses once; pooled = {7,9,11,19,21,23,31,33,35} (scaled by 256).
2. 6x6 input, all elements = -1.0 (0xFF00): relu_en=0 gives all nine slots 0xFF00; relu_en=1 gives all nine slots 0x0000.
3. Mixed signs in one window {0x8000, 0x7FFF, 0x0000, 0xFFFF} -> slot = 0x7FFF, confirming a signed compare rather than unsigned.
4. in_rows=5, in_cols=3 -> PR=2, PC=1; busy for 2 cycles; slots (0,0) and (1,0) computed and all others 0. in_rows=1 -> busy never asserts; done pulses the cycle after start.
5. Assert rst at the 4th POOL cycle -> next edge shows busy=0, done=0, pooled_matrix=0, and no done pulse follows. A fresh start then yields the correct full result.
6. Pulse start again during POOL, and change in_matrix after the start edge -> the result matches the originally latched frame, with exactly one done pulse.

Source files
------------

// File: rtl/relu_maxpool2x2.sv
// relu_maxpool2x2: ReLU + 2x2 stride-2 max pooling engine.
// Latches a filtered frame on start, evaluates one pooling window per clock.
module relu_maxpool2x2 #(
  parameter int total_bits = 16,
  parameter int frac_bits  = 8,
  parameter int max_rows   = 6,
  parameter int max_cols   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic relu_en,
  input  logic [3:0] in_rows,
  input  logic [3:0] in_cols,
  input  logic [max_rows*max_cols*total_bits-1:0] in_matrix,
  output logic busy,
  output logic done,
  output logic [(max_rows/2)*(max_cols/2)*total_bits-1:0] pooled_matrix
);

  localparam int PCOLS = max_cols / 2;
  localparam int PROWS = max_rows / 2;
  localparam int IW = max_rows * max_cols * total_bits;
  localparam int OW = PROWS * PCOLS * total_bits;

  localparam logic [3:0] MAXR = 4'(max_rows);
  localparam logic [3:0] MAXC = 4'(max_cols);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POOL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The fixed-point split does not affect max or ReLU; only sanity-check it.
  if (frac_bits >= total_bits) begin : g_bad_fmt
    $error("frac_bits must be smaller than total_bits");
  end

  logic [1:0] state;
  logic [IW-1:0] frame;
  logic [OW-1:0] pooled;
  logic relu_q;
  logic [3:0] pr, pc;
  logic [3:0] pr_lim, pc_lim;
  logic [3:0] r_eff, c_eff;

  logic signed [total_bits-1:0] e00, e01, e10, e11;
  logic signed [total_bits-1:0] m0, m1, mx, win_max;

  // Clamp the requested dims to the physical frame size.
  always_comb begin
    r_eff = (in_rows > MAXR) ? MAXR : in_rows;
    c_eff = (in_cols > MAXC) ? MAXC : in_cols;
  end

  // Pick the current 2x2 window from the latched frame and reduce it.
  always_comb begin
    int r0, c0;
    r0 = int'(pr) * 2;
    c0 = int'(pc) * 2;
    e00 = frame[(r0 * max_cols + c0) * total_bits +: total_bits];
    e01 = frame[(r0 * max_cols + c0 + 1) * total_bits +: total_bits];
    e10 = frame[((r0 + 1) * max_cols + c0) * total_bits +: total_bits];
    e11 = frame[((r0 + 1) * max_cols + c0 + 1) * total_bits +: total_bits];
    m0 = (e00 > e01) ? e00 : e01;
    m1 = (e10 > e11) ? e10 : e11;
    mx = (m0 > m1) ? m0 : m1;
    win_max = (relu_q && mx[total_bits-1]) ? '0 : mx;
  end

  // Control FSM, window counters and result storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      frame  <= '0;
      pooled <= '0;
      relu_q <= 1'b0;
      pr     <= '0;
      pc     <= '0;
      pr_lim <= '0;
      pc_lim <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            frame  <= in_matrix;
            relu_q <= relu_en;
            pr_lim <= r_eff >> 1;
            pc_lim <= c_eff >> 1;
            pooled <= '0;
            pr     <= '0;
            pc     <= '0;
            if (r_eff < 4'd2 || c_eff < 4'd2)
              state <= S_DONE;
            else
              state <= S_POOL;
          end
        end
        S_POOL: begin
          pooled[(int'(pr) * PCOLS + int'(pc)) * total_bits +: total_bits]
            <= win_max;
          if (pc == pc_lim - 4'd1) begin
            pc <= '0;
            if (pr == pr_lim - 4'd1)
              state <= S_DONE;
            else
              pr <= pr + 4'd1;
          end else begin
            pc <= pc + 4'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_POOL);
  assign done = (state == S_DONE);
  assign pooled_matrix = pooled;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// tb_relu_maxpool2x2: directed checks of relu_maxpool2x2.
// Hand-computed expected slots, latency, reset abort and ignored start.
module tb_relu_maxpool2x2;

  localparam int W = 16;
  localparam int N = 36;
  localparam int NO = 9;

  logic clk = 1'b0;
  logic rst, start, relu_en;
  logic [3:0] in_rows, in_cols;
  logic [N*W-1:0] in_matrix;
  logic busy, done;
  logic [NO*W-1:0] pooled_matrix;

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] exp_s [0:8];

  always #5 clk = ~clk;

  relu_maxpool2x2 dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .relu_en(relu_en),
    .in_rows(in_rows),
    .in_cols(in_cols),
    .in_matrix(in_matrix),
    .busy(busy),
    .done(done),
    .pooled_matrix(pooled_matrix)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        in_matrix[(r*6+c)*W +: W] = 16'((r*6+c)*256);
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < N; i++) in_matrix[i*W +: W] = v;
  endtask

  task automatic chk_slots(input string tag);
    for (int i = 0; i < NO; i++)
      chk($sformatf("%s_s%0d", tag, i),
          32'(pooled_matrix[i*W +: W]), 32'(exp_s[i]));
  endtask

  task automatic kick(input logic [3:0] rows, input logic [3:0] cols,
                      input logic relu);
    @(negedge clk);
    in_rows = rows;
    in_cols = cols;
    relu_en = relu;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input bit disturb, output int bcnt,
                     output int dfirst, output int dcnt);
    bcnt = 0;
    dfirst = -1;
    dcnt = 0;
    for (int k = 1; k <= 30; k++) begin
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (dfirst < 0) dfirst = k;
      end
      if (disturb && k == 3) begin
        start = 1'b1;
        fill_const(16'h7FFF);
      end
      if (disturb && k == 4) start = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bc, df, dc;
    rst = 1'b1;
    start = 1'b0;
    relu_en = 1'b0;
    in_rows = 4'd6;
    in_cols = 4'd6;
    in_matrix = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pooled", 32'(|pooled_matrix), 0);
    rst = 1'b0;

    // 1: ramp, no relu
    fill_ramp();
    kick(4'd6, 4'd6, 1'b0);
    run(1'b0, bc, df, dc);
    chk("ramp_busy", 32'(bc), 9);
    chk("ramp_done_at", 32'(df), 10);
    chk("ramp_done_cnt", 32'(dc), 1);
    exp_s = '{16'h0700, 16'h0900, 16'h0B00, 16'h1300, 16'h1500,
              16'h1700, 16'h1F00, 16'h2100, 16'h2300};
    chk_slots("ramp");

    // 2: all -1.0 with and without relu
    fill_const(16'hFF00);
    kick(4'd6, 4'd6, 1'b0);
    run(1'b0, bc, df, dc);
    chk("neg_done_cnt", 32'(dc), 1);
    for (int i = 0; i < NO; i++) exp_s[i] = 16'hFF00;
    chk_slots("neg");
    kick(4'd6, 4'd6, 1'b1);
    run(1'b0, bc, df, dc);
    chk("relu_done_cnt", 32'(dc), 1);
    for (int i = 0; i < NO; i++) exp_s[i] = 16'h0000;
    chk_slots("relu");

    // 3: signed compare in one 2x2 window
    fill_const(16'h0000);
    in_matrix[0*W +: W] = 16'h8000;
    in_matrix[1*W +: W] = 16'h7FFF;
    in_matrix[6*W +: W] = 16'h0000;
    in_matrix[7*W +: W] = 16'hFFFF;
    fill_const(16'h1234);
    in_matrix[0*W +: W] = 16'h8000;
    in_matrix[1*W +: W] = 16'h7FFF;
    in_matrix[6*W +: W] = 16'h0000;
    in_matrix[7*W +: W] = 16'hFFFF;
    kick(4'd2, 4'd2, 1'b0);
    run(1'b0, bc, df, dc);
    chk("sgn_busy", 32'(bc), 1);
    chk("sgn_done_at", 32'(df), 2);
    for (int i = 0; i < NO; i++) exp_s[i] = 16'h0000;
    exp_s[0] = 16'h7FFF;
    chk_slots("sgn");

    // 4: odd dims drop last row/col; degenerate dims
    fill_ramp();
    kick(4'd5, 4'd3, 1'b0);
    run(1'b0, bc, df, dc);
    chk("odd_busy", 32'(bc), 2);
    chk("odd_done_at", 32'(df), 3);
    for (int i = 0; i < NO; i++) exp_s[i] = 16'h0000;
    exp_s[0] = 16'h0700;
    exp_s[3] = 16'h1300;
    chk_slots("odd");
    kick(4'd1, 4'd6, 1'b0);
    run(1'b0, bc, df, dc);
    chk("row1_busy", 32'(bc), 0);
    chk("row1_done_at", 32'(df), 1);
    chk("row1_done_cnt", 32'(dc), 1);
    chk("row1_pooled", 32'(|pooled_matrix), 0);

    // 5: reset at 4th pool cycle aborts the frame
    fill_ramp();
    kick(4'd6, 4'd6, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_pre", 32'(busy), 1);
    chk("abort_pooled_pre", 32'(|pooled_matrix), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_pooled", 32'(|pooled_matrix), 0);
    run(1'b0, bc, df, dc);
    chk("abort_no_done", 32'(dc), 0);
    chk("abort_no_busy", 32'(bc), 0);
    kick(4'd6, 4'd6, 1'b0);
    run(1'b0, bc, df, dc);
    chk("fresh_done_at", 32'(df), 10);
    exp_s = '{16'h0700, 16'h0900, 16'h0B00, 16'h1300, 16'h1500,
              16'h1700, 16'h1F00, 16'h2100, 16'h2300};
    chk_slots("fresh");

    // 6: start during POOL ignored, input changes after start ignored
    fill_ramp();
    kick(4'd6, 4'd6, 1'b0);
    run(1'b1, bc, df, dc);
    chk("dist_busy", 32'(bc), 9);
    chk("dist_done_cnt", 32'(dc), 1);
    chk("dist_done_at", 32'(df), 10);
    chk_slots("dist");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
